// File: rtl/alu_result_collector_if.sv
// rtl/alu_result_collector_if.sv - ALU result lanes and common data bus signal bundle

interface alu_result_collector_if #(
   parameter int NUM_FU = 3,
   parameter int DATA_W = 32,
   parameter int PREG_W = 6,
   parameter int ROB_W  = 4
);
   logic [NUM_FU-1:0]        fu_valid;
   logic [NUM_FU-1:0]        fu_ready;
   logic [NUM_FU*DATA_W-1:0] fu_data;
   logic [NUM_FU*PREG_W-1:0] fu_preg;
   logic [NUM_FU*ROB_W-1:0]  fu_rob;

   logic                     cdb_valid;
   logic [DATA_W-1:0]        cdb_data;
   logic [PREG_W-1:0]        cdb_preg;
   logic [ROB_W-1:0]         cdb_rob;
   logic [1:0]               cdb_fu_id;
   logic                     busy;

   // ALU side: presents results, observes the broadcast bus
   modport master (
      output fu_valid, fu_data, fu_preg, fu_rob,
      input  fu_ready, cdb_valid, cdb_data, cdb_preg, cdb_rob, cdb_fu_id, busy
   );

   // Collector side: accepts results, drives the broadcast bus
   modport slave (
      input  fu_valid, fu_data, fu_preg, fu_rob,
      output fu_ready, cdb_valid, cdb_data, cdb_preg, cdb_rob, cdb_fu_id, busy
   );
endinterface

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - per-lane result FIFOs with round-robin arbitration onto a registered CDB

module alu_result_collector #(
   parameter int NUM_FU     = 3,
   parameter int DATA_W     = 32,
   parameter int PREG_W     = 6,
   parameter int ROB_W      = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   alu_result_collector_if.slave bus
);

   localparam int ENT_W = DATA_W + PREG_W + ROB_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ID_W  = 2;

   // Per-lane FIFO storage and bookkeeping
   logic [ENT_W-1:0] mem_q    [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
   logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
   logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
   logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
   logic [CNT_W-1:0] count_q  [NUM_FU];
   logic [CNT_W-1:0] count_d  [NUM_FU];
   logic [ENT_W-1:0] wr_entry [NUM_FU];

   logic [NUM_FU-1:0] ready;
   logic [NUM_FU-1:0] nonempty;
   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;

   // Arbitration state
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  rr_ptr_d;
   logic             grant_vld;
   logic [ID_W-1:0]  grant_idx;
   int               arb_idx;

   // Head of the granted lane
   logic [ENT_W-1:0]  head;
   logic [DATA_W-1:0] head_data;
   logic [PREG_W-1:0] head_preg;
   logic [ROB_W-1:0]  head_rob;

   // Registered CDB
   logic              cdb_valid_q, cdb_valid_d;
   logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
   logic [PREG_W-1:0] cdb_preg_q,  cdb_preg_d;
   logic [ROB_W-1:0]  cdb_rob_q,   cdb_rob_d;
   logic [ID_W-1:0]   cdb_fu_id_q, cdb_fu_id_d;

   // Lane status and handshake: ready depends only on the registered count, so a full lane
   // stays stalled even when it is about to pop
   always_comb begin
      ready    = '0;
      nonempty = '0;
      push     = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         ready[i]    = (count_q[i] < CNT_W'(FIFO_DEPTH));
         nonempty[i] = (count_q[i] != '0);
         push[i]     = bus.fu_valid[i] && ready[i] && !flush;
         wr_entry[i] = {bus.fu_data[i*DATA_W +: DATA_W],
                        bus.fu_preg[i*PREG_W +: PREG_W],
                        bus.fu_rob[i*ROB_W +: ROB_W]};
      end
   end

   // Round-robin search starting one past the last granted lane
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      arb_idx   = 0;
      for (int k = 1; k <= NUM_FU; k++) begin
         arb_idx = (int'(rr_ptr_q) + k) % NUM_FU;
         if (!grant_vld && nonempty[ID_W'(arb_idx)]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(arb_idx);
         end
      end
   end

   // Head entry of the granted lane and per-lane pop strobes
   always_comb begin
      head      = mem_q[grant_idx][rd_ptr_q[grant_idx]];
      head_data = head[ENT_W-1 -: DATA_W];
      head_preg = head[PREG_W+ROB_W-1 -: PREG_W];
      head_rob  = head[ROB_W-1:0];
      pop       = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         pop[i] = grant_vld && (grant_idx == ID_W'(i)) && !flush;
      end
   end

   // FIFO pointer/count next state; flush empties every lane
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         count_d[i]  = count_q[i];
         if (flush) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            count_d[i]  = '0;
         end else begin
            if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            case ({push[i], pop[i]})
               2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
               2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
               default: count_d[i] = count_q[i];
            endcase
         end
      end
   end

   // Arbiter pointer and CDB next state; a preg-0 head is consumed without a broadcast
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_data_d  = cdb_data_q;
      cdb_preg_d  = cdb_preg_q;
      cdb_rob_d   = cdb_rob_q;
      cdb_fu_id_d = cdb_fu_id_q;
      if (flush) begin
         rr_ptr_d = ID_W'(NUM_FU - 1);
      end else if (grant_vld) begin
         rr_ptr_d    = grant_idx;
         cdb_valid_d = (head_preg != '0);
         cdb_data_d  = head_data;
         cdb_preg_d  = head_preg;
         cdb_rob_d   = head_rob;
         cdb_fu_id_d = grant_idx;
      end
   end

   // FIFO payload write; storage needs no reset since the pointers gate what is visible
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (rstn && push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= wr_entry[i];
         end
      end
   end

   // Control and CDB state registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         rr_ptr_q    <= ID_W'(NUM_FU - 1);
         cdb_valid_q <= 1'b0;
         cdb_data_q  <= '0;
         cdb_preg_q  <= '0;
         cdb_rob_q   <= '0;
         cdb_fu_id_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_data_q  <= cdb_data_d;
         cdb_preg_q  <= cdb_preg_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_fu_id_q <= cdb_fu_id_d;
      end
   end

   assign bus.fu_ready  = ready;
   assign bus.busy      = |nonempty;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.cdb_preg  = cdb_preg_q;
   assign bus.cdb_rob   = cdb_rob_q;
   assign bus.cdb_fu_id = cdb_fu_id_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// tb/tb_alu_result_collector.sv - directed self-checking bench for alu_result_collector

module tb_alu_result_collector;

   localparam int NUM_FU = 3;
   localparam int DATA_W = 32;
   localparam int PREG_W = 6;
   localparam int ROB_W  = 4;

   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   alu_result_collector_if #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

   alu_result_collector #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W), .FIFO_DEPTH(2)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] it_d [3][8];
   logic [5:0]  it_p [3][8];
   logic [3:0]  it_r [3][8];
   int          n_items [3];
   int          fid_log [$];
   bit          saw_full0;
   int          cyc_used;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lane(input int i, input logic v, input logic [31:0] d,
                             input logic [5:0] p, input logic [3:0] r);
      bus.fu_valid[i]          = v;
      bus.fu_data[i*32 +: 32]  = d;
      bus.fu_preg[i*6 +: 6]    = p;
      bus.fu_rob[i*4 +: 4]     = r;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NUM_FU; i++) drive_lane(i, 1'b0, 32'h0, 6'h0, 4'h0);
   endtask

   // Drives each lane's item list honoring fu_ready and scoreboards every broadcast
   task automatic run_traffic(input string tag, input int budget, output int cycles);
      int          sent [3];
      int          recv [3];
      logic [2:0]  fire;
      int          l;
      bit          done;
      for (int i = 0; i < NUM_FU; i++) begin
         sent[i] = 0;
         recv[i] = 0;
      end
      fid_log.delete();
      saw_full0 = 1'b0;
      cycles    = 0;
      done      = 1'b0;
      while (!done && cycles < budget) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (sent[i] < n_items[i])
               drive_lane(i, 1'b1, it_d[i][sent[i]], it_p[i][sent[i]], it_r[i][sent[i]]);
            else
               drive_lane(i, 1'b0, 32'h0, 6'h0, 4'h0);
         end
         fire = bus.fu_valid & bus.fu_ready;
         if (n_items[0] > 0 && sent[0] < n_items[0] && !bus.fu_ready[0]) saw_full0 = 1'b1;
         step();
         cycles++;
         for (int i = 0; i < NUM_FU; i++) if (fire[i]) sent[i]++;
         if (bus.cdb_valid) begin
            l = int'(bus.cdb_fu_id);
            total++;
            assert (l < NUM_FU && recv[l] < n_items[l]) else begin
               bad++;
               $error("FAIL %s_unexpected_bcast observed fu_id=%0d rob=%0d expected no broadcast",
                      tag, l, bus.cdb_rob);
            end
            if (l < NUM_FU && recv[l] < n_items[l]) begin
               chk($sformatf("%s_data_l%0d_%0d", tag, l, recv[l]), 64'(bus.cdb_data), 64'(it_d[l][recv[l]]));
               chk($sformatf("%s_preg_l%0d_%0d", tag, l, recv[l]), 64'(bus.cdb_preg), 64'(it_p[l][recv[l]]));
               chk($sformatf("%s_rob_l%0d_%0d",  tag, l, recv[l]), 64'(bus.cdb_rob),  64'(it_r[l][recv[l]]));
               recv[l]++;
               fid_log.push_back(l);
            end
         end
         done = 1'b1;
         for (int i = 0; i < NUM_FU; i++) if (recv[i] != n_items[i]) done = 1'b0;
      end
      chk($sformatf("%s_all_delivered", tag), 64'(done), 64'd1);
      idle_all();
      step();
      chk($sformatf("%s_idle_valid", tag), 64'(bus.cdb_valid), 64'd0);
      chk($sformatf("%s_idle_busy", tag),  64'(bus.busy),      64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int exp_rr [6];
      exp_rr = '{0, 1, 2, 0, 1, 2};

      // Reset state
      idle_all();
      rstn = 1'b0;
      step();
      step();
      chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst_cdb_data",  64'(bus.cdb_data),  64'd0);
      chk("rst_cdb_preg",  64'(bus.cdb_preg),  64'd0);
      chk("rst_cdb_rob",   64'(bus.cdb_rob),   64'd0);
      chk("rst_cdb_fu_id", 64'(bus.cdb_fu_id), 64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      chk("rst_fu_ready",  64'(bus.fu_ready),  64'h7);
      rstn = 1'b1;
      step();

      // Single result on lane 1
      drive_lane(1, 1'b1, 32'h0000_00AB, 6'd5, 4'd3);
      step();
      idle_all();
      chk("single_e1_valid", 64'(bus.cdb_valid), 64'd0);
      chk("single_e1_busy",  64'(bus.busy),      64'd1);
      step();
      chk("single_e2_valid", 64'(bus.cdb_valid), 64'd1);
      chk("single_e2_data",  64'(bus.cdb_data),  64'hAB);
      chk("single_e2_preg",  64'(bus.cdb_preg),  64'd5);
      chk("single_e2_rob",   64'(bus.cdb_rob),   64'd3);
      chk("single_e2_fu_id", 64'(bus.cdb_fu_id), 64'd1);
      step();
      chk("single_e3_valid", 64'(bus.cdb_valid), 64'd0);
      chk("single_e3_busy",  64'(bus.busy),      64'd0);
      chk("single_e3_hold",  64'(bus.cdb_data),  64'hAB);

      // Flush restores lane-0-first priority
      flush = 1'b1;
      step();
      flush = 1'b0;

      // Round-robin fairness with all lanes saturated
      for (int i = 0; i < NUM_FU; i++) begin
         n_items[i] = 4;
         for (int k = 0; k < 4; k++) begin
            it_d[i][k] = 32'h1000 * (i + 1) + k;
            it_p[i][k] = 6'(10 * (i + 1));
            it_r[i][k] = 4'(4 * i + k);
         end
      end
      run_traffic("rr", 60, cyc_used);
      for (int k = 0; k < 6; k++) begin
         if (k < fid_log.size()) chk($sformatf("rr_order_%0d", k), 64'(fid_log[k]), 64'(exp_rr[k]));
         else                    chk($sformatf("rr_order_%0d", k), 64'(fid_log.size()), 64'd6);
      end
      chk("rr_fu_ready_dropped", 64'(saw_full0), 64'd1);

      // Backpressure on lane 0 with lanes 1 and 2 saturated
      for (int i = 0; i < NUM_FU; i++) begin
         n_items[i] = 4;
         for (int k = 0; k < 4; k++) begin
            it_d[i][k] = 32'hB000_0000 + 32'h100 * i + k;
            it_p[i][k] = 6'(1 + 4 * i + k);
            it_r[i][k] = 4'(15 - k);
         end
      end
      run_traffic("bp", 60, cyc_used);
      chk("bp_fu_ready0_low", 64'(saw_full0), 64'd1);
      chk("bp_count", 64'(fid_log.size()), 64'd12);

      // Pointer wrap: lane 2 alone, five back-to-back results
      n_items[0] = 0;
      n_items[1] = 0;
      n_items[2] = 5;
      for (int k = 0; k < 5; k++) begin
         it_d[2][k] = 32'hC0DE_0000 + k;
         it_p[2][k] = 6'd33;
         it_r[2][k] = 4'(k);
      end
      run_traffic("wrap", 30, cyc_used);
      chk("wrap_cycles", 64'(cyc_used), 64'd6);
      chk("wrap_count",  64'(fid_log.size()), 64'd5);

      // Preg 0 is popped but never broadcast
      drive_lane(0, 1'b1, 32'h1111_1111, 6'd0, 4'd1);
      step();
      chk("p0_e1_valid", 64'(bus.cdb_valid), 64'd0);
      drive_lane(0, 1'b1, 32'h2222_2222, 6'd7, 4'd2);
      step();
      idle_all();
      chk("p0_e2_valid", 64'(bus.cdb_valid), 64'd0);
      chk("p0_e2_busy",  64'(bus.busy),      64'd1);
      step();
      chk("p0_e3_valid", 64'(bus.cdb_valid), 64'd1);
      chk("p0_e3_preg",  64'(bus.cdb_preg),  64'd7);
      chk("p0_e3_data",  64'(bus.cdb_data),  64'h2222_2222);
      step();
      chk("p0_e4_valid", 64'(bus.cdb_valid), 64'd0);

      // Flush mid-operation, then the same scenario with reset
      for (int pass = 0; pass < 2; pass++) begin
         for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NUM_FU; i++) drive_lane(i, 1'b1, 32'h5A5A_0000 + c, 6'd1, 4'd0);
            step();
         end
         idle_all();
         chk($sformatf("mid%0d_busy_before", pass), 64'(bus.busy), 64'd1);
         drive_lane(0, 1'b1, 32'hDEAD_BEEF, 6'd9, 4'd9);
         if (pass == 0) flush = 1'b1;
         else           rstn  = 1'b0;
         step();
         flush = 1'b0;
         rstn  = 1'b1;
         idle_all();
         chk($sformatf("mid%0d_valid", pass),    64'(bus.cdb_valid), 64'd0);
         chk($sformatf("mid%0d_busy", pass),     64'(bus.busy),      64'd0);
         chk($sformatf("mid%0d_fu_ready", pass), 64'(bus.fu_ready),  64'h7);
         if (pass == 1) chk("mid1_rst_data", 64'(bus.cdb_data), 64'd0);
         for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid%0d_drop_%0d", pass, c), 64'(bus.cdb_valid), 64'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
